// File: rtl/input_conditioner.sv
// Push-button debouncer/pulse generator and busy-frozen operand synchronizer
// feeding the shift-add multiplier. Optional macro: RUN_QUEUE_EN (one-deep pending run).

// Per-button synchronizer + debounce FSM; raises accept for one cycle per debounced press.
//   state        | meaning
//   IDLE         | button released and stable
//   PRESS_WAIT   | low seen, counting consecutive low samples
//   HELD         | press accepted, waiting for release
//   RELEASE_WAIT | high seen, counting consecutive high samples
module input_conditioner_button #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic raw_n,
    output logic accept
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] TC_LOAD = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] TC_LAST = CW'(1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] remain, remain_nxt;
    logic [1:0]    sync_ff;
    logic          synced;

    assign synced = sync_ff[1];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync_ff <= 2'b11;
            state   <= IDLE;
            remain  <= '0;
        end else begin
            sync_ff <= {sync_ff[0], raw_n};
            state   <= state_nxt;
            remain  <= remain_nxt;
        end
    end

    // remain counts down the samples still needed; the first sample is taken on entry
    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (!synced) begin
                    state_nxt  = PRESS_WAIT;
                    remain_nxt = TC_LOAD;
                end
            end
            PRESS_WAIT: begin
                if (synced) begin
                    state_nxt  = IDLE;
                    remain_nxt = '0;
                end else if (remain == TC_LAST) begin
                    state_nxt  = HELD;
                    remain_nxt = '0;
                    accept     = 1'b1;
                end else begin
                    remain_nxt = remain - TC_LAST;
                end
            end
            HELD: begin
                if (synced) begin
                    state_nxt  = RELEASE_WAIT;
                    remain_nxt = TC_LOAD;
                end
            end
            RELEASE_WAIT: begin
                if (!synced) begin
                    state_nxt  = HELD;
                    remain_nxt = '0;
                end else if (remain == TC_LAST) begin
                    state_nxt  = IDLE;
                    remain_nxt = '0;
                end else begin
                    remain_nxt = remain - TC_LAST;
                end
            end
            default: begin
                state_nxt  = IDLE;
                remain_nxt = '0;
            end
        endcase
    end
endmodule

module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SW_WIDTH        = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Execute_n,
    input  logic                ClearA_LoadB_n,
    input  logic [SW_WIDTH-1:0] SW,
    input  logic                Busy,
    output logic                Run_pulse,
    output logic                ClearLoad_pulse,
    output logic [SW_WIDTH-1:0] S_out
);
    logic                run_acc, cl_acc;
    logic                run_nxt, cl_nxt;
    logic [SW_WIDTH-1:0] sw_sync1, sw_sync2;

    input_conditioner_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exec (
        .Clk    (Clk),
        .Reset  (Reset),
        .raw_n  (Execute_n),
        .accept (run_acc)
    );

    input_conditioner_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clld (
        .Clk    (Clk),
        .Reset  (Reset),
        .raw_n  (ClearA_LoadB_n),
        .accept (cl_acc)
    );

`ifdef RUN_QUEUE_EN
    logic pending_q, pending_nxt;

    // ClearLoad always beats a run, whether fresh or queued
    always_comb begin
        cl_nxt      = cl_acc & ~Busy;
        run_nxt     = 1'b0;
        pending_nxt = pending_q;
        if (Busy) begin
            if (run_acc && !cl_acc) begin
                pending_nxt = 1'b1;
            end
        end else if (cl_acc) begin
            pending_nxt = 1'b0;
        end else begin
            run_nxt     = run_acc | pending_q;
            pending_nxt = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_nxt;
        end
    end
`else
    always_comb begin
        cl_nxt  = cl_acc & ~Busy;
        run_nxt = run_acc & ~Busy & ~cl_acc;
    end
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Run_pulse       <= 1'b0;
            ClearLoad_pulse <= 1'b0;
            sw_sync1        <= '0;
            sw_sync2        <= '0;
            S_out           <= '0;
        end else begin
            Run_pulse       <= run_nxt;
            ClearLoad_pulse <= cl_nxt;
            sw_sync1        <= SW;
            sw_sync2        <= sw_sync1;
            if (!Busy) begin
                S_out <= sw_sync2;
            end
        end
    end
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner (DEBOUNCE_CYCLES=4) with a run-length debounce model.
module tb_input_conditioner;
    localparam int D = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Execute_n = 1'b1;
    logic       ClearA_LoadB_n = 1'b1;
    logic [7:0] SW = 8'h00;
    logic       Busy = 1'b0;
    logic       Run_pulse, ClearLoad_pulse;
    logic [7:0] S_out;

    int checks = 0;
    int errors = 0;
    int dut_run_cnt = 0;
    int dut_cl_cnt = 0;

    input_conditioner #(.DEBOUNCE_CYCLES(D), .SW_WIDTH(8)) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Execute_n       (Execute_n),
        .ClearA_LoadB_n  (ClearA_LoadB_n),
        .SW              (SW),
        .Busy            (Busy),
        .Run_pulse       (Run_pulse),
        .ClearLoad_pulse (ClearLoad_pulse),
        .S_out           (S_out)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: accepted level plus length of the current run of synced samples that disagree with it
    logic m_e1, m_e2, m_c1, m_c2, m_lvl_e, m_lvl_c, m_pend;
    logic [7:0] m_sw1, m_sw2;
    int   m_run_e, m_run_c;
    logic exp_run = 1'b0, exp_cl = 1'b0;
    logic [7:0] exp_s = 8'h00;

    function automatic void deb(input logic synced, inout logic lvl, inout int run,
                                output logic strobe);
        strobe = 1'b0;
        if (synced != lvl) begin
            run++;
            if (run == D) begin
                lvl = synced;
                run = 0;
                strobe = ~synced;
            end
        end else begin
            run = 0;
        end
    endfunction

    initial begin
        logic se, sc;
        forever begin
            @(posedge Clk or negedge Reset);
            if (!Reset) begin
                m_e1 = 1; m_e2 = 1; m_c1 = 1; m_c2 = 1;
                m_lvl_e = 1; m_lvl_c = 1; m_run_e = 0; m_run_c = 0;
                m_sw1 = 0; m_sw2 = 0; m_pend = 0;
                exp_run = 0; exp_cl = 0; exp_s = 0;
            end else begin
                deb(m_e2, m_lvl_e, m_run_e, se);
                deb(m_c2, m_lvl_c, m_run_c, sc);
                exp_cl = sc & ~Busy;
`ifdef RUN_QUEUE_EN
                exp_run = 1'b0;
                if (Busy) begin
                    if (se && !sc) m_pend = 1'b1;
                end else if (sc) begin
                    m_pend = 1'b0;
                end else begin
                    exp_run = se | m_pend;
                    m_pend = 1'b0;
                end
`else
                exp_run = se & ~Busy & ~sc;
`endif
                if (!Busy) exp_s = m_sw2;
                m_e2 = m_e1; m_e1 = Execute_n;
                m_c2 = m_c1; m_c1 = ClearA_LoadB_n;
                m_sw2 = m_sw1; m_sw1 = SW;
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clk);
            check("run_pulse", int'(Run_pulse), int'(exp_run));
            check("clearload_pulse", int'(ClearLoad_pulse), int'(exp_cl));
            check("s_out", int'(S_out), int'(exp_s));
            check("pulse_exclusive", int'(Run_pulse & ClearLoad_pulse), 0);
            if (Run_pulse) dut_run_cnt++;
            if (ClearLoad_pulse) dut_cl_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    initial begin
        int first_r, first_c, base_r, base_c, exp_q;

        // Reset and press latency
        tick(2);
        Reset = 1'b1;
        tick(3);
        check("reset_run", int'(Run_pulse), 0);
        check("reset_cl", int'(ClearLoad_pulse), 0);
        check("reset_s", int'(S_out), 0);
        base_r = dut_run_cnt;
        first_r = 0;
        Execute_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (Run_pulse && first_r == 0) first_r = i;
        end
        check("press_latency_edge", first_r, 6);
        check("press_one_pulse", dut_run_cnt - base_r, 1);
        base_r = dut_run_cnt;
        Execute_n = 1'b1;
        tick(12);
        check("release_no_pulse", dut_run_cnt - base_r, 0);

        // Bounce rejection
        base_c = dut_cl_cnt;
        for (int k = 0; k < 8; k++) begin
            ClearA_LoadB_n = (k % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        check("bounce_no_pulse", dut_cl_cnt - base_c, 0);
        first_c = 0;
        ClearA_LoadB_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (ClearLoad_pulse && first_c == 0) first_c = i;
        end
        check("bounce_latency_edge", first_c, 6);
        check("bounce_one_pulse", dut_cl_cnt - base_c, 1);
        ClearA_LoadB_n = 1'b1;
        tick(12);

        // Busy gating and freeze
        SW = 8'h07;
        tick(3);
        check("sw_3_edges", int'(S_out), 8'h07);
        Busy = 1'b1;
        SW = 8'hC5;
        Execute_n = 1'b0;
        base_r = dut_run_cnt;
        tick(20);
        check("busy_no_run", dut_run_cnt - base_r, 0);
        check("busy_freeze", int'(S_out), 8'h07);
        Busy = 1'b0;
        tick(1);
        check("unfreeze_1_edge", int'(S_out), 8'hC5);
        Execute_n = 1'b1;
        tick(12);

        // Simultaneous presses
        base_r = dut_run_cnt;
        base_c = dut_cl_cnt;
        first_c = 0;
        Execute_n = 1'b0;
        ClearA_LoadB_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (ClearLoad_pulse && first_c == 0) begin
                first_c = i;
                check("simul_run_low", int'(Run_pulse), 0);
            end
        end
        check("simul_cl_edge", first_c, 6);
        check("simul_no_run", dut_run_cnt - base_r, 0);
        check("simul_one_cl", dut_cl_cnt - base_c, 1);
        Execute_n = 1'b1;
        ClearA_LoadB_n = 1'b1;
        tick(12);

        // Reset mid-debounce with the button still held
        Execute_n = 1'b0;
        tick(4);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("in_reset_run", int'(Run_pulse), 0);
            check("in_reset_cl", int'(ClearLoad_pulse), 0);
            check("in_reset_s", int'(S_out), 0);
        end
        base_r = dut_run_cnt;
        first_r = 0;
        Reset = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (Run_pulse && first_r == 0) first_r = i;
        end
        check("rst_repress_edge", first_r, 6);
        check("rst_repress_one", dut_run_cnt - base_r, 1);
        Execute_n = 1'b1;
        tick(12);

        // Presses while busy, then drop busy
`ifdef RUN_QUEUE_EN
        exp_q = 1;
`else
        exp_q = 0;
`endif
        Busy = 1'b1;
        base_r = dut_run_cnt;
        for (int p = 0; p < 2; p++) begin
            Execute_n = 1'b0;
            tick(8);
            Execute_n = 1'b1;
            tick(12);
        end
        check("queue_none_busy", dut_run_cnt - base_r, 0);
        Busy = 1'b0;
        tick(1);
        check("queue_next_edge", int'(Run_pulse), exp_q);
        tick(5);
        check("queue_total", dut_run_cnt - base_r, exp_q);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
